// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and IF/ID outputs.
interface instr_fetch_stage_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              if_id_valid;
  logic [31:0]       if_id_instr;
  logic [ADDR_W-1:0] if_id_pc;
  logic [ADDR_W-1:0] if_id_pc4;
  logic              halted;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, halted
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, halted
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// RV32I IF stage: PC register, same-cycle instruction memory fetch, IF/ID register,
// stall/redirect handling and an optional HALT on fetch of an all-zero word.
module instr_fetch_stage #(
  parameter int unsigned        ADDR_W       = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
  parameter logic [31:0]        NOP_INSTR    = 32'h0000_0013,
  parameter bit                 HALT_ON_ZERO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_fetch_stage_if.master   bus
);

  typedef enum logic {RUN, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target;
  logic              valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] ifid_pc;
  logic [ADDR_W-1:0] ifid_pc4;
  logic              halted;

  // Wraps modulo 2**ADDR_W by truncation.
  assign pc_plus4 = pc + ADDR_W'(4);
  assign target   = {bus.redirect_pc[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      ifid_pc  <= '0;
      ifid_pc4 <= '0;
      halted   <= 1'b0;
    end else if (bus.redirect) begin
      // Redirect wins in both states and always returns to RUN.
      state  <= RUN;
      halted <= 1'b0;
      pc     <= target;
      valid  <= 1'b0;
      instr  <= NOP_INSTR;
    end else begin
      case (state)
        RUN: begin
          if (!bus.stall) begin
            valid    <= 1'b1;
            instr    <= bus.imem_rdata;
            ifid_pc  <= pc;
            ifid_pc4 <= pc_plus4;
            if (HALT_ON_ZERO && bus.imem_rdata == 32'h0) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        HALT: begin
          valid <= 1'b0;
          instr <= NOP_INSTR;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.if_id_valid = valid;
  assign bus.if_id_instr = instr;
  assign bus.if_id_pc    = ifid_pc;
  assign bus.if_id_pc4   = ifid_pc4;
  assign bus.halted      = halted;

endmodule
